// File: rtl/rx_sequencer_if.sv
// Serial receive control/status bundle between the host side and rx_sequencer.
interface rx_sequencer_if;
  logic serial_in;
  logic data_read;
  logic shift_enable;
  logic load_buffer;
  logic data_ready;
  logic overrun_error;
  logic framing_error;
  logic parity_error;

  modport master (
    output serial_in, data_read,
    input  shift_enable, load_buffer, data_ready,
    input  overrun_error, framing_error, parity_error
  );

  modport slave (
    input  serial_in, data_read,
    output shift_enable, load_buffer, data_ready,
    output overrun_error, framing_error, parity_error
  );
endinterface

// File: rtl/rx_sequencer.sv
// UART receive sequencer: start detect, bit timing, stop check, buffer/status flags.
// Optional even-parity stage enabled by defining RX_PARITY_EN.
module rx_sequencer #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8
) (
  input logic         clk,
  input logic         n_rst,
  rx_sequencer_if.slave rx
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    DATA,
`ifdef RX_PARITY_EN
    PARITY,
`endif
    STOP,
    LOAD
  } state_t;

  state_t            state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [BIT_W-1:0]  bit_cnt, bit_next;
  logic              prev;
  logic              shift_en;
  logic              load_en;
  logic              clr_flags;
  logic              set_framing;
  logic              data_ready;
  logic              overrun;
  logic              framing;
`ifdef RX_PARITY_EN
  logic              par_sample;
  logic              parity_acc;
  logic              parity_err;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      prev     <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      prev     <= rx.serial_in;
    end
  end

  // Sample decisions are taken in the last counted cycle of each interval,
  // so every pulse below is a combinational decode of state and counter.
  always_comb begin
    state_next  = state;
    baud_next   = baud_cnt + 1'b1;
    bit_next    = bit_cnt;
    shift_en    = 1'b0;
    load_en     = 1'b0;
    clr_flags   = 1'b0;
    set_framing = 1'b0;
`ifdef RX_PARITY_EN
    par_sample  = 1'b0;
`endif
    case (state)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (prev && !rx.serial_in) begin
          clr_flags  = 1'b1;
          state_next = START_CHK;
        end
      end
      START_CHK: begin
        if (baud_cnt == HALF_LAST) begin
          baud_next  = '0;
          state_next = rx.serial_in ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next = '0;
          shift_en  = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            bit_next = '0;
`ifdef RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next  = '0;
          par_sample = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next = '0;
          if (rx.serial_in) begin
            state_next = LOAD;
          end else begin
            set_framing = 1'b1;
            state_next  = IDLE;
          end
        end
      end
      LOAD: begin
        load_en    = 1'b1;
        baud_next  = '0;
        state_next = IDLE;
      end
      default: begin
        baud_next  = '0;
        bit_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // A read coinciding with a load keeps data_ready set and suppresses overrun.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_ready <= 1'b0;
      overrun    <= 1'b0;
      framing    <= 1'b0;
    end else begin
      if (load_en)
        data_ready <= 1'b1;
      else if (rx.data_read)
        data_ready <= 1'b0;

      if (load_en && data_ready && !rx.data_read)
        overrun <= 1'b1;
      else if (rx.data_read)
        overrun <= 1'b0;

      if (clr_flags)
        framing <= 1'b0;
      else if (set_framing)
        framing <= 1'b1;
    end
  end

`ifdef RX_PARITY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parity_acc <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (clr_flags) begin
        parity_acc <= 1'b0;
        parity_err <= 1'b0;
      end else begin
        if (shift_en)
          parity_acc <= parity_acc ^ rx.serial_in;
        if (par_sample && (parity_acc != rx.serial_in))
          parity_err <= 1'b1;
      end
    end
  end

  assign rx.parity_error = parity_err;
`else
  assign rx.parity_error = 1'b0;
`endif

  assign rx.shift_enable  = shift_en;
  assign rx.load_buffer   = load_en;
  assign rx.data_ready    = data_ready;
  assign rx.overrun_error = overrun;
  assign rx.framing_error = framing;

endmodule

// File: tb/tb_rx_sequencer.sv
// Scoreboard bench for rx_sequencer at CLKS_PER_BIT=10, DATA_BITS=8, parity disabled.
module tb_rx_sequencer;

  typedef struct {
    int cyc;
    bit is_load;
  } pulse_t;

  typedef struct {
    int         cyc;
    logic [3:0] flags;
  } status_t;

  logic clk = 1'b0;
  logic n_rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  pulse_t  pulse_q[$];
  status_t status_q[$];

  logic exp_ready = 1'b0;
  logic exp_ovr   = 1'b0;
  logic exp_frm   = 1'b0;

  rx_sequencer_if rx_bus ();

  rx_sequencer #(
    .CLKS_PER_BIT(10),
    .DATA_BITS   (8)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .rx   (rx_bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_pulse(input int c, input bit is_load);
    pulse_t p;
    p.cyc     = c;
    p.is_load = is_load;
    pulse_q.push_back(p);
  endtask

  task automatic push_status(input int c, input logic [3:0] f);
    status_t s;
    s.cyc   = c;
    s.flags = f;
    status_q.push_back(s);
  endtask

  // Monitor: compares DUT pulses and status flags against queued expectations.
  always @(negedge clk) begin
    pulse_t     p;
    status_t    s;
    logic [1:0] got;
    logic [3:0] fl;
    got = {rx_bus.shift_enable, rx_bus.load_buffer};
    if (got != 2'b00) begin
      checks++;
      if (pulse_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected cyc=%0d got shift/load=%b required none", cyc, got);
      end else begin
        p = pulse_q.pop_front();
        if (p.cyc != cyc || got != (p.is_load ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL pulse cyc=%0d got shift/load=%b required cyc=%0d shift/load=%b",
                   cyc, got, p.cyc, p.is_load ? 2'b01 : 2'b10);
        end
      end
    end else if (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
      checks++;
      errors++;
      p = pulse_q.pop_front();
      $display("FAIL pulse_missing cyc=%0d got none required load=%0b at cyc=%0d",
               cyc, p.is_load, p.cyc);
    end

    fl = {rx_bus.data_ready, rx_bus.overrun_error, rx_bus.framing_error, rx_bus.parity_error};
    while (status_q.size() > 0 && status_q[0].cyc <= cyc) begin
      s = status_q.pop_front();
      checks++;
      if (s.cyc != cyc || fl !== s.flags) begin
        errors++;
        $display("FAIL status cyc=%0d got rdy/ovr/frm/par=%b required %b at cyc=%0d",
                 cyc, fl, s.flags, s.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_read();
    int e;
    e = cyc;
    push_status(e, {exp_ready, exp_ovr, exp_frm, 1'b0});
    exp_ready = 1'b0;
    exp_ovr   = 1'b0;
    push_status(e + 1, {exp_ready, exp_ovr, exp_frm, 1'b0});
    rx_bus.data_read = 1'b1;
    idle(1);
    rx_bus.data_read = 1'b0;
    idle(4);
  endtask

  task automatic false_start();
    int e;
    e = cyc;
    push_status(e, {exp_ready, exp_ovr, exp_frm, 1'b0});
    exp_frm = 1'b0;
    push_status(e + 10, {exp_ready, exp_ovr, exp_frm, 1'b0});
    rx_bus.serial_in = 1'b0;
    idle(3);
    rx_bus.serial_in = 1'b1;
    idle(20);
  endtask

  // Edge at cycle e; rd drives data_read at e+96; abort_at>0 asserts n_rst at e+abort_at.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit rd, input int abort_at);
    logic [9:0] bits;
    int         e;
    bits = {stop, d, 1'b0};
    e = cyc;
    push_status(e, {exp_ready, exp_ovr, exp_frm, 1'b0});
    exp_frm = 1'b0;
    push_status(e + 1, {exp_ready, exp_ovr, 1'b0, 1'b0});
    for (int k = 0; k < 8; k++)
      if (abort_at == 0 || 15 + 10 * k < abort_at) push_pulse(e + 15 + 10 * k, 1'b0);
    if (abort_at != 0) begin
      push_status(e + abort_at, 4'b0000);
      exp_ready = 1'b0;
      exp_ovr   = 1'b0;
    end else if (stop) begin
      push_status(e + 96, {exp_ready, exp_ovr, 1'b0, 1'b0});
      push_pulse(e + 96, 1'b1);
      exp_ovr   = rd ? 1'b0 : exp_ready;
      exp_ready = 1'b1;
      push_status(e + 97, {exp_ready, exp_ovr, 1'b0, 1'b0});
    end else begin
      exp_frm = 1'b1;
      push_status(e + 96, {exp_ready, exp_ovr, 1'b1, 1'b0});
    end

    for (int t = 0; t < 100; t++) begin
      if (abort_at != 0 && t == abort_at) begin
        n_rst            = 1'b0;
        rx_bus.serial_in = 1'b1;
        break;
      end
      rx_bus.serial_in = bits[t / 10];
      rx_bus.data_read = rd && (t == 96);
      idle(1);
    end
    rx_bus.data_read = 1'b0;
    rx_bus.serial_in = 1'b1;

    if (abort_at != 0) begin
      idle(5);
      n_rst = 1'b1;
      push_status(cyc + 20, 4'b0000);
      idle(30);
    end else begin
      idle(5);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got no finish required finish", cyc);
    $fatal(1);
  end

  initial begin
    n_rst            = 1'b0;
    rx_bus.serial_in = 1'b1;
    rx_bus.data_read = 1'b0;
    idle(3);
    push_status(cyc, 4'b0000);
    n_rst = 1'b1;
    push_status(cyc + 2, 4'b0000);
    idle(5);

    send_frame(8'hA5, 1'b1, 1'b0, 0);   // basic frame
    host_read();
    false_start();
    send_frame(8'h3C, 1'b1, 1'b0, 0);   // normal reception after false start
    host_read();
    send_frame(8'h5A, 1'b0, 1'b0, 0);   // stop bit low
    send_frame(8'h0F, 1'b1, 1'b0, 0);   // clears framing_error
    send_frame(8'hF0, 1'b1, 1'b0, 0);   // overrun
    host_read();
    send_frame(8'h77, 1'b1, 1'b0, 0);
    send_frame(8'h88, 1'b1, 1'b1, 0);   // read coincides with load
    send_frame(8'h55, 1'b1, 1'b0, 40);  // reset mid-frame
    send_frame(8'h99, 1'b1, 1'b0, 0);
    idle(10);

    checks++;
    if (pulse_q.size() != 0) begin
      errors++;
      $display("FAIL pulse_queue_drain got %0d pending required 0", pulse_q.size());
    end
    checks++;
    if (status_q.size() != 0) begin
      errors++;
      $display("FAIL status_queue_drain got %0d pending required 0", status_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
